ofm_writeback_ctrl: RTL and testbench
=====================================

# ofm_writeback_ctrl

- Sequences the shared quantization/ReLU activation stage for the output feature map (OFM) write-back path.
- Round-robin arbitrates up to NUM_CH accumulator channels into the single activation unit, one element per cycle.
- Packs the returned 8-bit activations into PACK-byte words and writes them to the OFM buffer at consecutive addresses.
- Sits between the PE-array accumulators and the OFM SRAM; it is the only driver of the activation unit's inputs.

## Interface
- NUM_CH, 4: number of requesting accumulator channels.
- ACC_WIDTH, 32: accumulator / activation input width.
- OUT_WIDTH, 8: activation output width.
- PACK, 4: activations per OFM word; word width is PACK*OUT_WIDTH.
- ADDR_WIDTH, 12: OFM buffer address width.
- CNT_WIDTH, 16: element-count width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a job; ignored unless IDLE.
- base_addr, in, ADDR_WIDTH: first OFM word address, sampled on start.
- elem_count, in, CNT_WIDTH: total elements in the job, sampled on start.
- req, in, NUM_CH: channel i has valid acc_data[i].
- acc_data, in, NUM_CH x ACC_WIDTH: per-channel accumulator values.
- gnt, out, NUM_CH: one-hot combinational grant; the element is consumed on this edge.
- act_valid, out, 1: registered; drives activation ready_activation.
- act_data, out, ACC_WIDTH: registered; drives activation ofm_input.
- act_out, in, OUT_WIDTH: activation ofm_output.
- act_done, in, 1: activation ready_write; act_out is valid when this is high.
- wr_en, out, 1: OFM write strobe.
- wr_addr, out, ADDR_WIDTH: OFM write address.
- wr_data, out, PACK*OUT_WIDTH: OFM write word.
- busy, out, 1: high in RUN and FLUSH.
- done, out, 1: one-cycle pulse at job end.

## Operation
- **FSM states:** IDLE, RUN, FLUSH, DONE.
- **IDLE:** on start, latch base_addr and elem_count and clear all counters.
  - elem_count != 0: go to RUN.
  - elem_count == 0: go to DONE; no writes are issued.
- **RUN:** while issued < elem_count and any req is high, grant exactly one channel.
  - Grant is round-robin: after granting i, priority starts at (i+1) mod NUM_CH. The pointer is reset to 0.
  - On grant: act_valid <= 1 and act_data <= acc_data[granted]; issued increments.
  - If no req is high: gnt = 0 and act_valid <= 0.
  - Go to FLUSH on the edge where issued reaches elem_count.
- **Receive side (RUN and FLUSH):** each act_done cycle writes act_out into byte lane `lane` of the pack register, then lane increments and received increments.
  - Lane 0 holds the first element, at bits [7:0].
  - When lane == PACK-1, or the element is the last of the job: on the next cycle wr_en=1, wr_addr = base + word_cnt, wr_data = the pack register with unfilled lanes zero.
  - After the write, word_cnt increments, lane returns to 0 and the pack register clears.
- **FLUSH:** gnt = 0 and act_valid = 0. Go to DONE once received == elem_count and the final write has been issued.
- **DONE:** done=1 for one cycle, then return to IDLE.
- **Address range:** word addresses wrap modulo 2^ADDR_WIDTH.
- **Ignored inputs:**
  - act_done while IDLE or DONE.
  - start while busy.
  - req after issued == elem_count; no gnt is issued.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters 0.
- **Reset mid-job:** abandons the job immediately; no further wr_en is issued.
- **Issue path:** gnt at cycle t, then act_valid/act_data at t+1, then act_done at t+2 (activation latency 1). A word-completing element gives wr_en at t+3.
- **Throughput:** one element per cycle when req is continuously held.
- **Request gaps:** idle req cycles produce act_valid=0 and leave lane, counters and the pack register unchanged.
- **Job latency:** last grant at t_last gives done at t_last+4. A zero-length job gives done 2 cycles after start.
- **Output validity:** wr_data/wr_addr are valid only while wr_en=1.

## Structure
- Package ofm_ctrl_pkg holds:
  - the state enum type;
  - the PACK and OUT_WIDTH defaults;
  - the helper localparam WORD_WIDTH = PACK*OUT_WIDTH.
- Sub-module rr_arbiter, parameterized by NUM_CH, provides:
  - inputs req and advance;
  - a one-hot gnt output;
  - the rotating priority pointer.
- The FSM, counters and pack register stay in ofm_writeback_ctrl.
- The bench instantiates the real activation unit behind act_valid/act_data.

## Test plan
- **Single channel, elem_count=4, base 0x010:** acc values 0x12000000, 0x34000000, 0x80000000, 0x7F000000.
  - Expect one write: addr 0x010, data 0x7F003412.
  - Expect done 4 cycles after the last gnt.
- **All four req held high, elem_count=8:** gnt order ch0,1,2,3,0,1,2,3 in consecutive cycles; writes at base and base+1.
- **elem_count=5, acc 0x05000000 repeated:** first write 0x05050505; second write 0x00000005 at base+1.
- **elem_count=0:** done 2 cycles after start; no gnt, no act_valid, no wr_en.
- **Sparse req (1 cycle on, 2 off), elem_count=4:** same packed word as a back-to-back run; act_valid low on the off cycles.
- **rst_n low during RUN with 2 bytes packed:** all outputs 0, no write, state IDLE.
  - A new start then begins at lane 0 of the new base.

Source files
------------

// File: rtl/ofm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ofm_ctrl_pkg
//   Shared definitions for the OFM write-back controller: the FSM state
//   encoding, default activation packing geometry and the derived OFM word
//   width.
// ----------------------------------------------------------------------------
package ofm_ctrl_pkg;

  // Default packing geometry: PACK activations of OUT_WIDTH bits per word.
  localparam int PACK_DEF      = 4;
  localparam int OUT_WIDTH_DEF = 8;
  localparam int WORD_WIDTH    = PACK_DEF * OUT_WIDTH_DEF;

  // Legacy-compatible state constants; the enum below uses the same codes.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/ofm_writeback_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer. The search starts at
//   the pointer; after a channel is granted and advance is asserted, the
//   pointer moves to the channel after the granted one.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   clear      : synchronous pointer clear (new job)
//   req        : per-channel request vector
//   advance    : the current grant was taken; rotate the pointer
//   gnt        : one-hot combinational grant (all zero when req is zero)
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan channels in priority order starting at the pointer; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'((int'(ptr_reg) + k) % NUM_CH);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (clear) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/ofm_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// ofm_writeback_ctrl
//   Feeds accumulator channels, one element per cycle in round-robin order,
//   into the shared quantization/ReLU unit, packs the returned 8-bit
//   activations into PACK-lane words and writes them to consecutive OFM
//   buffer addresses starting at base_addr.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : job start pulse (accepted only in IDLE)
//   base_addr           : first OFM word address (sampled on start)
//   elem_count          : number of elements in the job (sampled on start)
//   req / acc_data      : per-channel request and accumulator value
//   gnt                 : one-hot combinational grant; element taken this edge
//   act_valid/act_data  : registered input strobe/data to the activation unit
//   act_out/act_done    : activation result and its valid strobe
//   wr_en/wr_addr/wr_data : OFM buffer write port
//   busy                : job in progress (RUN or FLUSH)
//   done                : one-cycle job completion pulse
// ----------------------------------------------------------------------------
module ofm_writeback_ctrl
  import ofm_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int PACK       = PACK_DEF,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [CNT_WIDTH-1:0]               elem_count,
  input  logic [NUM_CH-1:0]                  req,
  input  logic [NUM_CH-1:0][ACC_WIDTH-1:0]   acc_data,
  output logic [NUM_CH-1:0]                  gnt,
  output logic                               act_valid,
  output logic [ACC_WIDTH-1:0]               act_data,
  input  logic [OUT_WIDTH-1:0]               act_out,
  input  logic                               act_done,
  output logic                               wr_en,
  output logic [ADDR_WIDTH-1:0]              wr_addr,
  output logic [PACK*OUT_WIDTH-1:0]          wr_data,
  output logic                               busy,
  output logic                               done
);

  localparam int WORD_W = PACK * OUT_WIDTH;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [CNT_WIDTH-1:0]    count_reg;
  logic [CNT_WIDTH-1:0]    issued_reg;
  logic [CNT_WIDTH-1:0]    received_reg;
  logic [ADDR_WIDTH-1:0]   word_cnt_reg;
  logic [LANE_W-1:0]       lane_reg;
  logic [WORD_W-1:0]       pack_reg;
  logic [WORD_W-1:0]       pack_next;
  logic [OUT_WIDTH-1:0]    lane_next [PACK];

  logic                    act_valid_reg;
  logic [ACC_WIDTH-1:0]    act_data_reg;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [WORD_W-1:0]       wr_data_reg;
  logic                    done_reg;

  logic                    start_accept;
  logic                    issue_en;
  logic [NUM_CH-1:0]       arb_req;
  logic [NUM_CH-1:0]       arb_gnt;
  logic                    grant_any;
  logic [ACC_WIDTH-1:0]    granted_data;
  logic                    recv_en;
  logic                    last_elem;
  logic                    word_full;

  assign start_accept = (state_reg == IDLE) && start;
  // Requests only reach the arbiter while elements remain to be issued.
  assign issue_en     = (state_reg == RUN) && (issued_reg != count_reg);
  assign arb_req      = req & {NUM_CH{issue_en}};
  assign grant_any    = |arb_gnt;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_accept),
    .req     (arb_req),
    .advance (grant_any),
    .gnt     (arb_gnt)
  );

  // One-hot grant makes an OR-reduction mux sufficient.
  always_comb begin
    granted_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        granted_data = granted_data | acc_data[i];
      end
    end
  end

  assign recv_en   = act_done && ((state_reg == RUN) || (state_reg == FLUSH));
  assign last_elem = (received_reg + CNT_WIDTH'(1)) == count_reg;
  assign word_full = recv_en && ((lane_reg == LANE_W'(PACK - 1)) || last_elem);

  // Pack register with the incoming activation dropped into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      assign lane_next[gi] = (recv_en && (lane_reg == LANE_W'(gi)))
                             ? act_out
                             : pack_reg[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  always_comb begin
    pack_next = '0;
    for (int i = 0; i < PACK; i++) begin
      pack_next[i*OUT_WIDTH +: OUT_WIDTH] = lane_next[i];
    end
  end

  // The job ends on the edge that receives its last element; the final
  // write strobe is registered on that same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (elem_count == '0) ? DONE : RUN;
      RUN:     if (grant_any && ((issued_reg + CNT_WIDTH'(1)) == count_reg))
                 state_next = FLUSH;
      FLUSH:   if (recv_en && last_elem) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      count_reg     <= '0;
      issued_reg    <= '0;
      received_reg  <= '0;
      word_cnt_reg  <= '0;
      lane_reg      <= '0;
      pack_reg      <= '0;
      act_valid_reg <= 1'b0;
      act_data_reg  <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // done trails the DONE state by one cycle: a zero-length job pulses
      // done two cycles after start, a normal job four after its last grant.
      done_reg      <= (state_reg == DONE);
      act_valid_reg <= grant_any;
      if (grant_any) begin
        act_data_reg <= granted_data;
      end
      wr_en_reg <= 1'b0;

      if (start_accept) begin
        base_reg     <= base_addr;
        count_reg    <= elem_count;
        issued_reg   <= '0;
        received_reg <= '0;
        word_cnt_reg <= '0;
        lane_reg     <= '0;
        pack_reg     <= '0;
      end else begin
        if (grant_any) begin
          issued_reg <= issued_reg + CNT_WIDTH'(1);
        end
        if (recv_en) begin
          received_reg <= received_reg + CNT_WIDTH'(1);
          if (word_full) begin
            wr_en_reg    <= 1'b1;
            wr_addr_reg  <= base_reg + word_cnt_reg;  // wraps modulo 2^ADDR_WIDTH
            wr_data_reg  <= pack_next;
            word_cnt_reg <= word_cnt_reg + ADDR_WIDTH'(1);
            lane_reg     <= '0;
            pack_reg     <= '0;
          end else begin
            lane_reg     <= lane_reg + LANE_W'(1);
            pack_reg     <= pack_next;
          end
        end
      end
    end
  end

  assign gnt       = arb_gnt;
  assign act_valid = act_valid_reg;
  assign act_data  = act_data_reg;
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy      = (state_reg == RUN) || (state_reg == FLUSH);
  assign done      = done_reg;

endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ofm_writeback_ctrl
//   Directed bench for ofm_writeback_ctrl with a one-cycle quantization/ReLU
//   stand-in behind act_valid/act_data (top byte of the accumulator, negative
//   values clamp to zero). A negedge monitor logs grants, activation strobes,
//   writes and done pulses by cycle number; the directed steps then compare
//   the logs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ofm_writeback_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [11:0]      base_addr;
  logic [15:0]      elem_count;
  logic [3:0]       req;
  logic [3:0][31:0] acc_data;
  logic [3:0]       gnt;
  logic             act_valid;
  logic [31:0]      act_data;
  logic [7:0]       act_out;
  logic             act_done;
  logic             wr_en;
  logic [11:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  ofm_writeback_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .elem_count (elem_count),
    .req        (req),
    .acc_data   (acc_data),
    .gnt        (gnt),
    .act_valid  (act_valid),
    .act_data   (act_data),
    .act_out    (act_out),
    .act_done   (act_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  // Activation unit stand-in, latency 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_done <= 1'b0;
      act_out  <= 8'h00;
    end else begin
      act_done <= act_valid;
      act_out  <= act_data[31] ? 8'h00 : act_data[31:24];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          gnt_cyc[$];
  logic [3:0]  gnt_val[$];
  int          av_cyc[$];
  int          wr_cyc[$];
  logic [11:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (gnt != 4'b0) begin
      gnt_cyc.push_back(cyc);
      gnt_val.push_back(gnt);
    end
    if (act_valid) av_cyc.push_back(cyc);
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      wr_addr_q.push_back(wr_addr);
      wr_data_q.push_back(wr_data);
      $display("write: cycle %0d addr %03h data %08h", cyc, wr_addr, wr_data);
    end
    if (done) done_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_cyc.delete(); gnt_val.delete(); av_cyc.delete();
    wr_cyc.delete(); wr_addr_q.delete(); wr_data_q.delete(); done_cyc.delete();
  endtask

  // Pulses start for one cycle; s is the cycle in which start is high.
  task automatic start_job(input logic [11:0] b, input logic [15:0] n, output int s);
    start      = 1'b1;
    base_addr  = b;
    elem_count = n;
    s          = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && done_cyc.size() == 0; i++) tick();
    chk({tag, "_done_seen"}, done_cyc.size(), 1);
    repeat (3) tick();
  endtask

  logic [31:0] v1 [4] = '{32'h12000000, 32'h34000000, 32'h80000000, 32'h7F000000};
  logic [3:0]  exp_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int s;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; elem_count = '0;
    req = '0; acc_data = '0;
    repeat (3) tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_outputs", {wr_addr, wr_data, act_data}, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: single channel, four elements, one word.
    clear_logs();
    start_job(12'h010, 16'd4, s);
    for (int j = 0; j < 4; j++) begin
      req = 4'b0001; acc_data[0] = v1[j];
      tick();
    end
    req = '0;
    wait_done("t1");
    chk("t1_gnt_count", gnt_cyc.size(), 4);
    chk("t1_wr_count", wr_cyc.size(), 1);
    if (gnt_cyc.size() == 4) begin
      chk("t1_first_gnt_cycle", gnt_cyc[0] - s, 1);
      chk("t1_gnt_ch", gnt_val[3], 4'b0001);
    end
    if (wr_cyc.size() == 1) begin
      chk("t1_wr_addr", wr_addr_q[0], 12'h010);
      chk("t1_wr_data", wr_data_q[0], 32'h7F003412);
      chk("t1_wr_cycle", wr_cyc[0] - s, 7);
    end
    if (done_cyc.size() == 1) chk("t1_done_latency", done_cyc[0] - s, 8);
    $display("t1 done: %0d checks, %0d errors so far", checks, errors);

    // Test 2: all four channels held, eight elements, base wraps at 0xFFF.
    clear_logs();
    start_job(12'hFFF, 16'd8, s);
    for (int i = 0; i < 4; i++) acc_data[i] = 32'((i + 1) * 8'h11) << 24;
    req = 4'hF;
    wait_done("t2");
    req = '0;
    chk("t2_gnt_count", gnt_cyc.size(), 8);
    if (gnt_cyc.size() == 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("t2_gnt_order%0d", k), gnt_val[k], exp_gnt[k]);
      chk("t2_gnt_span", gnt_cyc[7] - gnt_cyc[0], 7);
    end
    chk("t2_wr_count", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
      chk("t2_wr_addr0", wr_addr_q[0], 12'hFFF);
      chk("t2_wr_addr1", wr_addr_q[1], 12'h000);
      chk("t2_wr_data0", wr_data_q[0], 32'h44332211);
      chk("t2_wr_data1", wr_data_q[1], 32'h44332211);
    end
    if (done_cyc.size() == 1) chk("t2_done_latency", done_cyc[0] - s, 12);
    $display("t2 done: %0d checks, %0d errors so far", checks, errors);

    // Test 3: five elements, partial second word zero-filled.
    clear_logs();
    start_job(12'h100, 16'd5, s);
    acc_data[0] = 32'h05000000;
    req = 4'b0001;
    wait_done("t3");
    req = '0;
    chk("t3_gnt_count", gnt_cyc.size(), 5);
    chk("t3_wr_count", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
      chk("t3_wr_data0", wr_data_q[0], 32'h05050505);
      chk("t3_wr_addr0", wr_addr_q[0], 12'h100);
      chk("t3_wr_data1", wr_data_q[1], 32'h00000005);
      chk("t3_wr_addr1", wr_addr_q[1], 12'h101);
    end
    if (done_cyc.size() == 1) chk("t3_done_latency", done_cyc[0] - s, 9);
    $display("t3 done: %0d checks, %0d errors so far", checks, errors);

    // Test 4: zero-length job with requests present.
    clear_logs();
    start_job(12'h040, 16'd0, s);
    req = 4'hF;
    wait_done("t4");
    req = '0;
    if (done_cyc.size() == 1) chk("t4_done_latency", done_cyc[0] - s, 2);
    chk("t4_no_gnt", gnt_cyc.size(), 0);
    chk("t4_no_act_valid", av_cyc.size(), 0);
    chk("t4_no_wr", wr_cyc.size(), 0);
    $display("t4 done: %0d checks, %0d errors so far", checks, errors);

    // Test 5: sparse requests, one cycle on, two off.
    clear_logs();
    start_job(12'h020, 16'd4, s);
    for (int j = 0; j < 4; j++) begin
      req = 4'b0001; acc_data[0] = v1[j];
      tick();
      req = '0;
      tick();
      tick();
    end
    wait_done("t5");
    chk("t5_gnt_count", gnt_cyc.size(), 4);
    chk("t5_av_count", av_cyc.size(), 4);
    if (gnt_cyc.size() == 4 && av_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("t5_av_follows_gnt%0d", k), av_cyc[k] - gnt_cyc[k], 1);
      chk("t5_gnt_spacing", gnt_cyc[1] - gnt_cyc[0], 3);
    end
    chk("t5_wr_count", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) begin
      chk("t5_wr_data", wr_data_q[0], 32'h7F003412);
      chk("t5_wr_addr", wr_addr_q[0], 12'h020);
    end
    if (done_cyc.size() == 1) chk("t5_done_latency", done_cyc[0] - s, 14);
    $display("t5 done: %0d checks, %0d errors so far", checks, errors);

    // Test 6: reset in RUN with two bytes packed, then a fresh job.
    clear_logs();
    start_job(12'h200, 16'd8, s);
    req = 4'b0001; acc_data[0] = 32'h11000000;
    tick();
    acc_data[0] = 32'h22000000;
    tick();
    req = '0;
    tick();
    tick();
    chk("t6_busy_before_rst", busy, 1);
    chk("t6_no_wr_before_rst", wr_cyc.size(), 0);
    rst_n = 1'b0;
    #3;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_act_valid", act_valid, 0);
    chk("t6_rst_outputs", {wr_addr, wr_data, act_data, gnt}, 0);
    tick();
    tick();
    chk("t6_no_wr_during_rst", wr_cyc.size(), 0);
    rst_n = 1'b1;
    tick();
    clear_logs();
    start_job(12'h300, 16'd1, s);
    req = 4'b0001; acc_data[0] = 32'h5A000000;
    tick();
    req = '0;
    wait_done("t6");
    chk("t6_wr_count", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) begin
      chk("t6_wr_addr", wr_addr_q[0], 12'h300);
      chk("t6_wr_data", wr_data_q[0], 32'h0000005A);
    end
    if (done_cyc.size() == 1) chk("t6_done_latency", done_cyc[0] - s, 5);
    $display("t6 done: %0d checks, %0d errors so far", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
